approx_mul_sched: RTL and testbench

- Sequential front-end that shares one instance of the combinational 32x32 approximate radix-4 Booth multiplier core (radix4approx, M2 variant) between two requesters.
- Per-requester valid/ready input handshake; round-robin grant.
- Registers operands into the core and registers the 64-bit product.
- Returns the product on a single valid/ready result channel, tagged with the winning requester id.
- Sits between the accelerator's operand fetch ports and its accumulation stage.

---
 rtl/approx_mul_pkg.sv | 15 +
 rtl/approx_mul_sched_core.sv | 64 ++++++
 rtl/approx_mul_sched_rr_arb2.sv | 24 ++
 rtl/approx_mul_sched.sv | 152 +++++++++++++++
 tb/tb_approx_mul_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the approximate-multiplier scheduler.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_TAG_W = 4;
  // Low multiplicand bits collapsed by the core into a single majority bit.
  localparam int APPROX_BITS   = 24;

endpackage

// File: rtl/approx_mul_sched_core.sv
// radix4approx (M2): low multiplicand bits replaced by their majority, then unsigned radix-4 Booth product.
module radix4approx
  import approx_mul_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);

  localparam int CW  = $clog2(APPROX_BITS + 1);
  localparam int NPP = (N + 2) / 2;

  logic [CW-1:0]    ones;
  logic             maj;
  logic [N-1:0]     xa;
  logic [2*N-1:0]   xa_ext;
  logic [N+2:0]     ye;
  logic [2*N-1:0]   pp [NPP];
  logic [2*N-1:0]   acc;

  always_comb begin
    ones = '0;
    for (int i = 0; i < APPROX_BITS; i++) begin
      ones = ones + CW'(x[i]);
    end
  end

  // Strict majority: more than half of the low bits set.
  assign maj    = (ones > CW'(APPROX_BITS / 2));
  assign xa     = {x[N-1:APPROX_BITS], maj, {(APPROX_BITS-1){1'b0}}};
  assign xa_ext = {{N{1'b0}}, xa};
  // Two zero MSBs make the unsigned multiplier look positive to the Booth recoder.
  assign ye     = {2'b00, y, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_pp
      logic [2:0]     trip;
      logic [2*N-1:0] mag;
      assign trip = ye[2*gi+2 -: 3];
      always_comb begin
        mag = '0;
        case (trip)
          3'b001, 3'b010, 3'b101, 3'b110: mag = xa_ext;
          3'b011, 3'b100:                 mag = xa_ext << 1;
          default:                        mag = '0;
        endcase
      end
      assign pp[gi] = (trip[2] ? (~mag + 1'b1) : mag) << (2 * gi);
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int i = 0; i < NPP; i++) begin
      acc = acc + pp[i];
    end
  end

  assign p = acc;

endmodule

// File: rtl/approx_mul_sched_rr_arb2.sv
// Combinational two-way round-robin arbiter; the priority pointer is held by the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr;
      default: gnt_id = 1'b0;
    endcase
    if (en && (req != 2'b00)) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/approx_mul_sched.sv
// Two-requester round-robin front-end sharing one radix4approx core.
// Optional APPROX_MUL_EXACT_EN adds per-request exact-product selection.
module approx_mul_sched
  import approx_mul_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*N-1:0]     req_x,
  input  logic [2*N-1:0]     req_y,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*N-1:0]     res_p,
  output logic               res_id,
  output logic [TAG_W-1:0]   res_tag,
`ifdef APPROX_MUL_EXACT_EN
  input  logic [1:0]         req_exact,
  output logic               res_exact,
`endif
  output logic               busy
);

  state_t             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [N-1:0]       x_q, x_d, y_q, y_d;
  logic [TAG_W-1:0]   tag_q, tag_d, res_tag_q, res_tag_d;
  logic               id_q, id_d, res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;
  logic [2*N-1:0]     res_p_q, res_p_d;
  logic [2*N-1:0]     core_p, mul_p;
  logic               grant_en, gnt_id;
  logic [1:0]         gnt;

  // A grant is only offered while the result slot is empty or being drained.
  assign grant_en = ~rst & ((state_q == IDLE) | ((state_q == DONE) & res_ready));

  rr_arb2 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (grant_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  radix4approx #(.N(N)) u_core (
    .x (x_q),
    .y (y_q),
    .p (core_p)
  );

`ifdef APPROX_MUL_EXACT_EN
  logic exact_q, exact_d, res_exact_q, res_exact_d;
  assign mul_p     = exact_q ? ({{N{1'b0}}, x_q} * {{N{1'b0}}, y_q}) : core_p;
  assign res_exact = res_exact_q;
`else
  assign mul_p = core_p;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    tag_d       = tag_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_p_d     = res_p_q;
    res_id_d    = res_id_q;
    res_tag_d   = res_tag_q;
`ifdef APPROX_MUL_EXACT_EN
    exact_d     = exact_q;
    res_exact_d = res_exact_q;
`endif
    if (gnt != 2'b00) begin
      x_d      = gnt_id ? req_x[2*N-1:N] : req_x[N-1:0];
      y_d      = gnt_id ? req_y[2*N-1:N] : req_y[N-1:0];
      tag_d    = gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
      id_d     = gnt_id;
      rr_ptr_d = ~gnt_id;
      state_d  = MUL;
`ifdef APPROX_MUL_EXACT_EN
      exact_d  = gnt_id ? req_exact[1] : req_exact[0];
`endif
    end
    case (state_q)
      MUL: begin
        res_p_d     = mul_p;
        res_id_d    = id_q;
        res_tag_d   = tag_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
`ifdef APPROX_MUL_EXACT_EN
        res_exact_d = exact_q;
`endif
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (gnt == 2'b00) state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      tag_q       <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_p_q     <= '0;
      res_id_q    <= 1'b0;
      res_tag_q   <= '0;
`ifdef APPROX_MUL_EXACT_EN
      exact_q     <= 1'b0;
      res_exact_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tag_q       <= tag_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_p_q     <= res_p_d;
      res_id_q    <= res_id_d;
      res_tag_q   <= res_tag_d;
`ifdef APPROX_MUL_EXACT_EN
      exact_q     <= exact_d;
      res_exact_q <= res_exact_d;
`endif
    end
  end

  assign req_ready = gnt;
  assign res_valid = res_valid_q;
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;
  assign res_tag   = res_tag_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_approx_mul_sched.sv
// Self-checking bench for approx_mul_sched: vector table, random ops, and handshake corner sequences.
module tb_approx_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_x, req_y;
  logic [7:0]  req_tag;
  logic        res_valid, res_ready;
  logic [63:0] res_p;
  logic        res_id;
  logic [3:0]  res_tag;
  logic        busy;
`ifdef APPROX_MUL_EXACT_EN
  logic [1:0]  req_exact;
  logic        res_exact;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  approx_mul_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .res_tag   (res_tag),
`ifdef APPROX_MUL_EXACT_EN
    .req_exact (req_exact),
    .res_exact (res_exact),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: low 24 bits of x collapse to their strict majority at bit 23; y is used as-is.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] xn;
    xn       = x;
    xn[22:0] = '0;
    xn[23]   = ($countones(x[23:0]) > 12);
    return {32'b0, xn} * {32'b0, y};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag);
    req_x[id*32 +: 32] = x;
    req_y[id*32 +: 32] = y;
    req_tag[id*4 +: 4] = tag;
  endtask

  task automatic do_op(input int id, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] tag, input int exact, input int stall, input string nm);
    logic [63:0] exp;
    logic [1:0]  oh;
    exp = (exact != 0) ? ({32'b0, x} * {32'b0, y}) : ref_mul(x, y);
    oh  = (id == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    req_valid = oh;
    set_req(id, x, y, tag);
`ifdef APPROX_MUL_EXACT_EN
    req_exact     = '0;
    req_exact[id] = (exact != 0);
`endif
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 8 && req_ready !== oh; k++) begin
      @(negedge clk);
      #1;
    end
    chk({nm, ".req_ready"}, 64'(req_ready), 64'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    res_ready = (stall == 0);
    #1;
    chk({nm, ".mul_valid"}, 64'(res_valid), 64'(0));
    chk({nm, ".mul_busy"}, 64'(busy), 64'(1));
    @(negedge clk);
    #1;
    chk({nm, ".res_valid"}, 64'(res_valid), 64'(1));
    chk({nm, ".res_p"}, res_p, exp);
    chk({nm, ".res_id"}, 64'(res_id), 64'(id));
    chk({nm, ".res_tag"}, 64'(res_tag), 64'(tag));
`ifdef APPROX_MUL_EXACT_EN
    chk({nm, ".res_exact"}, 64'(res_exact), 64'(exact != 0));
`endif
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      chk({nm, ".bp_ready"}, 64'(req_ready), 64'(0));
      chk({nm, ".bp_valid"}, 64'(res_valid), 64'(1));
      chk({nm, ".bp_p"}, res_p, exp);
    end
    if (stall > 0) begin
      @(negedge clk);
      req_valid = 2'b00;
      res_ready = 1'b1;
      #1;
      chk({nm, ".bp_hold"}, 64'(res_valid), 64'(1));
    end
    @(negedge clk);
    #1;
    chk({nm, ".idle_busy"}, 64'(busy), 64'(0));
    chk({nm, ".idle_valid"}, 64'(res_valid), 64'(0));
    $display("op %s id=%0d x=%h y=%h tag=%h exp=%h got=%h", nm, id, x, y, tag, exp, res_p);
  endtask

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  tag;
    int          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{0, 32'h0100_0000, 32'd3,          4'h5, 0, 64'h0000_0000_0300_0000};
    vt[1] = '{0, 32'h00FF_FFFF, 32'd1,          4'h1, 0, 64'h0000_0000_0080_0000};
    vt[2] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  4'h7, 5, 64'hFF7F_FFFF_0080_0000};
    vt[3] = '{1, 32'h1200_0000, 32'h10,         4'hA, 0, 64'h0000_0001_2000_0000};
    vt[4] = '{0, 32'h0000_1FFF, 32'd2,          4'h3, 1, 64'h0000_0000_0100_0000};
    vt[5] = '{1, 32'h0000_07FF, 32'h1234,       4'hF, 0, 64'h0000_0000_0000_0000};

    rst       = 1'b1;
    req_valid = 2'b11;
    req_x     = '0;
    req_y     = '0;
    req_tag   = '0;
    res_ready = 1'b0;
`ifdef APPROX_MUL_EXACT_EN
    req_exact = '0;
`endif
    #2;
    chk("reset.req_ready", 64'(req_ready), 64'(0));
    chk("reset.res_valid", 64'(res_valid), 64'(0));
    chk("reset.res_p", res_p, 64'(0));
    chk("reset.res_id_tag", 64'({res_id, res_tag}), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rst       = 1'b0;

    // Table: hand-computed expected products, cross-checked against the reference model.
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d.model", i), ref_mul(vt[i].x, vt[i].y), vt[i].exp);
      do_op(vt[i].id, vt[i].x, vt[i].y, vt[i].tag, 0, vt[i].stall, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      logic [31:0] rx;
      rx = $urandom;
      if (i % 4 == 0) rx = rx & 32'hFF00_0000;
      do_op(int'($urandom_range(0, 1)), rx, $urandom, 4'($urandom), 0,
            int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    // Contention from reset: id0 first, then id1 by round-robin, two cycles apart.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 32'h0200_0000, 32'd2, 4'h1);
    set_req(1, 32'h0100_0000, 32'd7, 4'h2);
    req_valid = 2'b11;
    res_ready = 1'b1;
    #1;
    chk("cont.grant0", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    #1;
    chk("cont.mul_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("cont.valid0", 64'(res_valid), 64'(1));
    chk("cont.p0", res_p, 64'h0400_0000);
    chk("cont.id0", 64'({res_id, res_tag}), 64'({1'b0, 4'h1}));
    chk("cont.grant1", 64'(req_ready), 64'(2'b10));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("cont.gap", 64'(res_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("cont.valid1", 64'(res_valid), 64'(1));
    chk("cont.p1", res_p, 64'h0700_0000);
    chk("cont.id1", 64'({res_id, res_tag}), 64'({1'b1, 4'h2}));
    $display("op contention results id0=%h id1=%h", 64'h0400_0000, res_p);
    @(negedge clk);

    // Reset during MUL drops the op and restores the round-robin pointer.
    @(negedge clk);
    set_req(0, 32'h0100_0000, 32'd3, 4'h5);
    req_valid = 2'b01;
    #1;
    chk("rstmid.grant", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b11;
    rst       = 1'b1;
    #1;
    chk("rstmid.valid", 64'(res_valid), 64'(0));
    chk("rstmid.busy", 64'(busy), 64'(0));
    chk("rstmid.ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.ptr0", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rstmid.no_result", 64'(res_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("rstmid.res_p", res_p, 64'h0300_0000);
    chk("rstmid.res_id_tag", 64'({res_id, res_tag}), 64'({1'b0, 4'h5}));
    $display("op reset-mid-op follow-up res_p=%h", res_p);
    @(negedge clk);

`ifdef APPROX_MUL_EXACT_EN
    do_op(0, 32'h00FF_FFFF, 32'd1, 4'h2, 1, 0, "exact");
    chk("exact.value", res_p, 64'h00FF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
